pad_input_conditioner: RTL and testbench
========================================

Name: pad_input_conditioner

Overview:
- Input-side companion to the FPGA pad wrapper. Takes raw per-pad input values returned by the pad cells, before they reach the core's pad mux.
- Per pad, it provides:
  - metastability synchronization;
  - an optional programmable glitch filter;
  - single-cycle rise and fall event pulses.
- Feeds GPIO/event logic with clean, clock-domain-safe pad levels.

Parameters:
- N_IO, 48, number of pads handled (matches the pad count of the top-level wrapper).
- SYNC_STAGES, 2, synchronizer flop depth per pad (legal 2..4).
- FILT_W, 8, width of the filter length field and of each per-pad counter.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- io_in_i  in  N_IO  raw pad input values (asynchronous to clk_i).
- filt_en_i  in  N_IO  per-pad glitch-filter enable (quasi-static config).
- filt_len_i  in  FILT_W  global filter length L, shared by all pads.
- io_sync_o  out  N_IO  synchronized pad levels (last synchronizer stage).
- io_filt_o  out  N_IO  filtered, registered pad levels.
- rise_o  out  N_IO  one-cycle pulse on each 0->1 change of io_filt_o.
- fall_o  out  N_IO  one-cycle pulse on each 1->0 change of io_filt_o.
- any_edge_o  out  1  registered OR of all rise_o and fall_o bits, aligned with them.

Behaviour:
- Reset (asynchronous, active-high):
  - all synchronizer flops, filter counters, io_sync_o, io_filt_o, rise_o, fall_o and any_edge_o clear to 0;
  - assertion mid-operation clears immediately; no pulse is generated on the reset edge.
- Synchronizer:
  - io_sync_o[i] equals io_in_i[i] delayed by SYNC_STAGES rising edges;
  - no combinational path from io_in_i to any output.
- Filter, per pad i, with s = io_sync_o[i], f = io_filt_o[i], cnt[i] of FILT_W bits, L = filt_len_i:
  - filt_en_i[i] = 0 (bypass): f <= s every cycle; cnt[i] <= 0.
  - filt_en_i[i] = 1 and s == f: cnt[i] <= 0; f holds.
  - filt_en_i[i] = 1, s != f and cnt[i] >= L: f <= s; cnt[i] <= 0.
  - filt_en_i[i] = 1, s != f and cnt[i] < L: cnt[i] <= cnt[i] + 1; f holds.
- Resulting latency:
  - a level must differ from f for L+1 consecutive cycles to be accepted;
  - L = 0 is identical to bypass;
  - total pad-to-io_filt_o latency is SYNC_STAGES + L + 1 cycles.
- Glitch handling: any return of s to f before acceptance restarts the count from 0. The counter cannot overflow, because it stops at L <= 2^FILT_W - 1.
- Config changes while running:
  - filt_len_i decreasing mid-count: the >= comparison accepts on the next differing cycle;
  - filt_en_i deasserting mid-count: f takes s on the next edge and the count is discarded.
- Edges:
  - rise_o[i] is registered and equals (f_next & ~f), so it is high exactly in the first cycle io_filt_o[i] reads 1;
  - fall_o[i] is the symmetric case;
  - rise_o and fall_o are never both high on one pad;
  - any_edge_o is computed from the same next-state terms, so it is high in the same cycle as the pulses.
- Pad held high through reset release: rise_o pulses once, SYNC_STAGES + L + 1 cycles after release. This is intentional; consumers ignore events until enabled.
- Pads are fully independent; simultaneous events on multiple pads produce simultaneous pulses.

Test Plan:
1. Reset and bypass.
   - Stimulus: rst_i pulse, then filt_en_i = 0 and io_in_i[3] 0->1.
   - Required: all outputs 0 during reset. io_sync_o[3] = 1 after 2 cycles; io_filt_o[3] = 1 and rise_o[3] = 1 for one cycle at cycle 3; any_edge_o matches.
2. Filter acceptance.
   - Stimulus: filt_en_i[7] = 1, L = 4, io_in_i[7] held high.
   - Required: io_filt_o[7] rises exactly 2 + 5 = 7 cycles after the input edge with one rise_o[7] pulse. Releasing the input gives fall_o[7] 7 cycles later.
3. Glitch rejection.
   - Stimulus: L = 4; a 3-cycle-wide high pulse on io_in_i[7], then a 10-cycle-wide pulse.
   - Required: no output change or pulse for the first pulse. For the second: one rise, then one fall, each at 7 cycles latency.
4. Restart on bounce.
   - Stimulus: L = 3; input high 3 cycles, low 1, high 10.
   - Required: acceptance 4 synchronized-cycles after the final rising level, not earlier.
5. Config change mid-count.
   - Stimulus: L = 200, input raised; after 10 cycles set L = 5.
   - Required: io_filt_o updates on the next clock. Separately, clearing filt_en_i mid-count gives an update on the next clock.
6. Reset mid-operation, multi-pad.
   - Stimulus: pads 0, 20 and 47 all toggle in the same cycle with L = 0; then rst_i asserted while pad 20 is counting with L = 10.
   - Required: three simultaneous rise pulses and any_edge_o = 1 for one cycle. Reset clears counters and outputs asynchronously, with no pulse generated.

Source files
------------

// File: rtl/pad_input_conditioner.sv
// Pad input conditioner: per-pad synchronizer, glitch filter, edge pulses.
// A new level is accepted once it differs from io_filt_o for L+1 cycles.
module pad_input_conditioner #(
    parameter int N_IO        = 48,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_IO-1:0]   io_in_i,
    input  logic [N_IO-1:0]   filt_en_i,
    input  logic [FILT_W-1:0] filt_len_i,
    output logic [N_IO-1:0]   io_sync_o,
    output logic [N_IO-1:0]   io_filt_o,
    output logic [N_IO-1:0]   rise_o,
    output logic [N_IO-1:0]   fall_o,
    output logic              any_edge_o
);

    logic [SYNC_STAGES-1:0][N_IO-1:0] r_sync;
    logic [N_IO-1:0][FILT_W-1:0]      r_cnt;
    logic [N_IO-1:0][FILT_W-1:0]      w_cnt_nxt;
    logic [N_IO-1:0]                  r_filt;
    logic [N_IO-1:0]                  r_rise;
    logic [N_IO-1:0]                  r_fall;
    logic                             r_any;
    logic [N_IO-1:0]                  w_sync;
    logic [N_IO-1:0]                  w_filt_nxt;
    logic [N_IO-1:0]                  w_rise;
    logic [N_IO-1:0]                  w_fall;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= io_in_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Counter saturates at L by construction: reaching L accepts.
    always_comb begin
        w_filt_nxt = r_filt;
        w_cnt_nxt  = '0;
        for (int i = 0; i < N_IO; i++) begin
            if (!filt_en_i[i]) begin
                w_filt_nxt[i] = w_sync[i];
            end else if (w_sync[i] != r_filt[i]) begin
                if (r_cnt[i] >= filt_len_i) begin
                    w_filt_nxt[i] = w_sync[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + FILT_W'(1);
                end
            end
        end
    end

    assign w_rise = w_filt_nxt & ~r_filt;
    assign w_fall = r_filt & ~w_filt_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_filt <= '0;
            r_cnt  <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_any  <= 1'b0;
        end else begin
            r_filt <= w_filt_nxt;
            r_cnt  <= w_cnt_nxt;
            r_rise <= w_rise;
            r_fall <= w_fall;
            r_any  <= |(w_rise | w_fall);
        end
    end

    assign io_sync_o  = w_sync;
    assign io_filt_o  = r_filt;
    assign rise_o     = r_rise;
    assign fall_o     = r_fall;
    assign any_edge_o = r_any;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Testbench for pad_input_conditioner: directed scenarios plus random
// traffic against a run-length reference model.
module tb_pad_input_conditioner;

    localparam int N = 48;
    localparam int S = 2;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] io_in;
    logic [N-1:0] filt_en;
    logic [W-1:0] filt_len;
    logic [N-1:0] io_sync_o;
    logic [N-1:0] io_filt_o;
    logic [N-1:0] rise_o;
    logic [N-1:0] fall_o;
    logic         any_edge_o;

    int n_checks = 0;
    int n_fail   = 0;

    pad_input_conditioner #(
        .N_IO(N),
        .SYNC_STAGES(S),
        .FILT_W(W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .io_in_i(io_in),
        .filt_en_i(filt_en),
        .filt_len_i(filt_len),
        .io_sync_o(io_sync_o),
        .io_filt_o(io_filt_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .any_edge_o(any_edge_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: sync is a pure delay line; a pad accepts a new
    // level when it has differed from the filtered level for L+1 edges
    // in a row (tracked as the edge index of the last "agreeing" edge).
    logic [N-1:0] m_sync = '0;
    logic [N-1:0] m_filt = '0;
    logic [N-1:0] m_rise = '0;
    logic [N-1:0] m_fall = '0;
    logic         m_any  = 1'b0;
    logic [N-1:0] m_nf;
    logic [N-1:0] m_pipe[$];
    longint       m_cyc  = 0;
    longint       m_since[N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pipe.delete();
            for (int k = 0; k < S - 1; k++) m_pipe.push_back('0);
            m_sync = '0;
            m_filt = '0;
            m_rise = '0;
            m_fall = '0;
            m_any  = 1'b0;
            for (int i = 0; i < N; i++) m_since[i] = m_cyc;
        end else begin
            m_cyc++;
            m_nf = m_filt;
            for (int i = 0; i < N; i++) begin
                if (!filt_en[i] || m_sync[i] == m_filt[i]) begin
                    m_nf[i] = filt_en[i] ? m_filt[i] : m_sync[i];
                    m_since[i] = m_cyc;
                end else if (m_cyc - m_since[i] >= longint'(filt_len) + 1) begin
                    m_nf[i] = m_sync[i];
                    m_since[i] = m_cyc;
                end
            end
            m_rise = m_nf & ~m_filt;
            m_fall = m_filt & ~m_nf;
            m_any  = |(m_rise | m_fall);
            m_filt = m_nf;
            m_pipe.push_back(io_in);
            m_sync = m_pipe.pop_front();
        end
    end

    wire [4*N:0] dut_v = {io_sync_o, io_filt_o, rise_o, fall_o, any_edge_o};
    wire [4*N:0] m_v   = {m_sync, m_filt, m_rise, m_fall, m_any};

    task automatic test_reset();
        rst = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            io_in = N'({$urandom, $urandom});
            @(negedge clk);
            n_checks++;
            if (dut_v !== '0) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d got %h want 0", c, dut_v);
            end
        end
        io_in = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== '0 || dut_v !== m_v) begin
                n_fail++;
                $display("FAIL reset_release c=%0d got %h want %h", c, dut_v, m_v);
            end
        end
    endtask

    task automatic test_bypass();
        filt_en  = '0;
        filt_len = '0;
        io_in[3] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v) begin
                n_fail++;
                $display("FAIL bypass_model c=%0d got %h want %h", c, dut_v, m_v);
            end
            n_checks++;
            if ({io_sync_o[3], io_filt_o[3], rise_o[3], any_edge_o} !==
                {c >= 2, c >= 3, c == 3, c == 3}) begin
                n_fail++;
                $display("FAIL bypass_pad3 c=%0d got %b want %b", c,
                    {io_sync_o[3], io_filt_o[3], rise_o[3], any_edge_o},
                    {c >= 2, c >= 3, c == 3, c == 3});
            end
        end
        io_in[3] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v) begin
                n_fail++;
                $display("FAIL bypass_fall c=%0d got %h want %h", c, dut_v, m_v);
            end
        end
    endtask

    task automatic test_filter_accept();
        filt_en[7] = 1'b1;
        filt_len   = 8'd4;
        io_in[7]   = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v ||
                {io_filt_o[7], rise_o[7], fall_o[7]} !== {c >= 7, c == 7, 1'b0}) begin
                n_fail++;
                $display("FAIL accept_rise c=%0d got %h want %h", c, dut_v, m_v);
            end
        end
        io_in[7] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v ||
                {io_filt_o[7], rise_o[7], fall_o[7]} !== {c < 7, 1'b0, c == 7}) begin
                n_fail++;
                $display("FAIL accept_fall c=%0d got %h want %h", c, dut_v, m_v);
            end
        end
    endtask

    task automatic test_glitch();
        filt_len = 8'd4;
        io_in[7] = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v || {io_filt_o[7], rise_o[7], fall_o[7]} !== 3'b000) begin
                n_fail++;
                $display("FAIL glitch_short c=%0d got %h want %h", c, dut_v, m_v);
            end
            io_in[7] = (c < 3);
        end
        io_in[7] = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v || {io_filt_o[7], rise_o[7], fall_o[7]} !==
                {c >= 7 && c < 17, c == 7, c == 17}) begin
                n_fail++;
                $display("FAIL glitch_long c=%0d got %h want %h", c, dut_v, m_v);
            end
            io_in[7] = (c < 10);
        end
    endtask

    task automatic test_bounce();
        filt_len = 8'd3;
        io_in[7] = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v || {io_filt_o[7], rise_o[7], fall_o[7]} !==
                {c >= 10 && c < 20, c == 10, c == 20}) begin
                n_fail++;
                $display("FAIL bounce c=%0d got %h want %h", c, dut_v, m_v);
            end
            io_in[7] = (c < 3) || (c >= 4 && c < 14);
        end
    endtask

    task automatic test_config_change();
        filt_len = 8'd200;
        io_in[7] = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v || {io_filt_o[7], rise_o[7], fall_o[7]} !==
                {c >= 11 && c < 20, c == 11, c == 20}) begin
                n_fail++;
                $display("FAIL cfg_len c=%0d got %h want %h", c, dut_v, m_v);
            end
            if (c == 10) filt_len = 8'd5;
            if (c == 12) io_in[7] = 1'b0;
        end
        filt_len = 8'd200;
        io_in[7] = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v || {io_filt_o[7], rise_o[7], fall_o[7]} !==
                {c >= 11 && c < 15, c == 11, c == 15}) begin
                n_fail++;
                $display("FAIL cfg_en c=%0d got %h want %h", c, dut_v, m_v);
            end
            if (c == 10) filt_en[7] = 1'b0;
            if (c == 12) io_in[7] = 1'b0;
        end
    endtask

    task automatic test_multi_reset();
        logic [N-1:0] mask;
        mask = '0;
        mask[0] = 1'b1;
        mask[20] = 1'b1;
        mask[47] = 1'b1;
        filt_en  = mask;
        filt_len = 8'd0;
        io_in    = mask;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v || rise_o !== (c == 3 ? mask : '0) ||
                any_edge_o !== (c == 3)) begin
                n_fail++;
                $display("FAIL multi_rise c=%0d got %h want %h", c, dut_v, m_v);
            end
        end
        filt_len  = 8'd10;
        io_in[20] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v || io_filt_o[20] !== 1'b1) begin
                n_fail++;
                $display("FAIL multi_count c=%0d got %h want %h", c, dut_v, m_v);
            end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut_v !== '0) begin
            n_fail++;
            $display("FAIL async_reset got %h want 0", dut_v);
        end
        io_in = mask;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== '0) begin
                n_fail++;
                $display("FAIL reset_nopulse c=%0d got %h want 0", c, dut_v);
            end
        end
        rst = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v || rise_o !== (c == 13 ? mask : '0)) begin
                n_fail++;
                $display("FAIL post_reset c=%0d got %h want %h", c, dut_v, m_v);
            end
        end
        io_in   = '0;
        filt_en = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v) begin
                n_fail++;
                $display("FAIL multi_settle c=%0d got %h want %h", c, dut_v, m_v);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) begin
                filt_en  = N'({$urandom, $urandom});
                filt_len = W'($urandom_range(0, 5));
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) io_in[i] = ~io_in[i];
            end
            @(negedge clk);
            n_checks++;
            if (dut_v !== m_v || (rise_o & fall_o) !== '0) begin
                n_fail++;
                $display("FAIL random c=%0d got %h want %h", c, dut_v, m_v);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        io_in    = '0;
        filt_en  = '0;
        filt_len = '0;
        test_reset();
        test_bypass();
        test_filter_accept();
        test_glitch();
        test_bounce();
        test_config_change();
        test_multi_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_checks, n_fail);
        $finish;
    end

endmodule
